// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART state encoding and baud divider defaults
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD_RATE = 115_200;

  // Rounded clock-cycles-per-bit; the receiver derives its divider the same way.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int DEFAULT_BAUD_DIV = baud_div(CLK_HZ, BAUD_RATE);

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter emitting a one-cycle tick at BAUD_DIV-1
module uart_baud_tick
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int PRELOAD  = 0,
  localparam int CW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  logic [CW-1:0] count;

  // Count 0..BAUD_DIV-1 and wrap; clear reloads PRELOAD (0 for TX, half period for RX).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= CW'(PRELOAD);
    end else if (count == CW'(BAUD_DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == CW'(BAUD_DIV - 1)) && !clear;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - asynchronous serial transmitter draining a fall-through FIFO
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_dequeue,
  output logic                  tx,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic                  tx_next, busy_next;
  logic                  tick, baud_clear;

  // New frames start only from IDLE; held off during reset so nothing is popped then.
  assign fifo_dequeue = (state == S_IDLE) && enable && !fifo_empty && !rst;

  // Baud phase is held at zero in IDLE so every frame is aligned to its dequeue.
  assign baud_clear = (state == S_IDLE);

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV),
    .PRELOAD (0)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Next-state, shift and bit-count logic; tx/busy are derived from the next state.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    case (state)
      S_IDLE: begin
        if (fifo_dequeue) begin
          state_next = S_START;
          shift_next = fifo_data;
        end
      end
      S_START: begin
        if (tick) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            state_next   = S_STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            state_next = S_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE);
  end

  // State register with registered line outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       deq1, tx1, busy1;

  logic       en2, empty2;
  logic [7:0] data2;
  logic       deq2, tx2, busy2;

  logic [7:0] mem [0:15];
  int         rd = 0;
  int         wr = 0;
  int         cyc = 0;
  int         deq_n = 0;
  int         deq2_n = 0;
  int         deq_at [0:7];

  int nerr = 0;
  int nchk = 0;

  uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_DIV(4), .STOP_BITS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_dequeue(deq1),
    .tx          (tx1),
    .busy        (busy1)
  );

  uart_tx_fifo #(.DATA_WIDTH(8), .BAUD_DIV(4), .STOP_BITS(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .enable      (en2),
    .fifo_empty  (empty2),
    .fifo_data   (data2),
    .fifo_dequeue(deq2),
    .tx          (tx2),
    .busy        (busy2)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd == wr);
  assign fifo_data  = mem[rd[3:0]];

  // FIFO pop model plus dequeue bookkeeping for both instances.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (deq1) begin
      rd    <= rd + 1;
      deq_n <= deq_n + 1;
      if (deq_n < 8) deq_at[deq_n] <= cyc;
    end
    if (deq2) deq2_n <= deq2_n + 1;
  end

  task automatic push(input logic [7:0] v);
    mem[wr[3:0]] = v;
    wr = wr + 1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks ncyc cycles (full frame when negative) of a frame of v; optionally drops enable at cycle drop_at.
  task automatic check_frame(input logic [7:0] v, input int which, input int sb,
                             input int ncyc, input int drop_at);
    int   total;
    int   lim;
    int   b;
    logic e;
    total = (9 + sb) * 4;
    lim   = (ncyc < 0) ? total : ncyc;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      b = k / 4;
      if (b == 0)      e = 1'b0;
      else if (b <= 8) e = v[b-1];
      else             e = 1'b1;
      if (which == 1) begin
        chk({31'd0, tx1},   {31'd0, e}, $sformatf("frame_tx[%0h k=%0d]", v, k));
        chk({31'd0, busy1}, 32'd1,      $sformatf("frame_busy[%0h k=%0d]", v, k));
        chk({31'd0, deq1},  32'd0,      $sformatf("frame_deq[%0h k=%0d]", v, k));
      end else begin
        chk({31'd0, tx2},   {31'd0, e}, $sformatf("frame2_tx[%0h k=%0d]", v, k));
        chk({31'd0, busy2}, 32'd1,      $sformatf("frame2_busy[%0h k=%0d]", v, k));
        chk({31'd0, deq2},  32'd0,      $sformatf("frame2_deq[%0h k=%0d]", v, k));
      end
      if (k == drop_at) enable = 1'b0;
    end
  endtask

  task automatic check_idle1(input string tag);
    chk({31'd0, tx1},   32'd1, {tag, "_tx"});
    chk({31'd0, busy1}, 32'd0, {tag, "_busy"});
  endtask

  // Directed sequence of all scenarios.
  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    en2    = 1'b1;
    empty2 = 1'b1;
    data2  = 8'h00;
    push(8'hA5);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle1("reset");
      chk({31'd0, deq1}, 32'd0, "reset_deq");
    end
    rst = 1'b0;
    #1;
    chk({31'd0, deq1}, 32'd1, "first_deq");

    check_frame(8'hA5, 1, 1, -1, -1);
    @(negedge clk);
    check_idle1("after_a5");
    chk({31'd0, deq1}, 32'd0, "after_a5_deq");
    chk(deq_n, 32'd1, "a5_deq_count");

    push(8'h00);
    push(8'hFF);
    #1;
    chk({31'd0, deq1}, 32'd1, "b2b_deq0");
    check_frame(8'h00, 1, 1, -1, -1);
    @(negedge clk);
    check_idle1("b2b_gap");
    chk({31'd0, deq1}, 32'd1, "b2b_deq1");
    check_frame(8'hFF, 1, 1, -1, -1);
    @(negedge clk);
    check_idle1("after_b2b");
    chk({31'd0, deq1}, 32'd0, "after_b2b_deq");
    chk(deq_at[2] - deq_at[1], 32'd41, "b2b_period");

    enable = 1'b0;
    push(8'h5A);
    push(8'h3C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({31'd0, deq1}, 32'd0, "disabled_deq");
      chk({31'd0, tx1},  32'd1, "disabled_tx");
    end
    enable = 1'b1;
    #1;
    chk({31'd0, deq1}, 32'd1, "enable_deq");
    check_frame(8'h5A, 1, 1, -1, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle1("drop_en_idle");
      chk({31'd0, deq1}, 32'd0, "drop_en_deq");
    end
    chk(deq_n, 32'd4, "drop_en_count");

    push(8'h96);
    enable = 1'b1;
    #1;
    chk({31'd0, deq1}, 32'd1, "rst_frame_deq");
    check_frame(8'h3C, 1, 1, 18, -1);
    rst = 1'b1;
    @(negedge clk);
    check_idle1("midframe_rst");
    chk({31'd0, deq1}, 32'd0, "midframe_rst_deq");
    rst = 1'b0;
    #1;
    chk({31'd0, deq1}, 32'd1, "post_rst_deq");
    chk(deq_n, 32'd5, "post_rst_count");
    check_frame(8'h96, 1, 1, -1, -1);
    @(negedge clk);
    check_idle1("after_96");
    chk({31'd0, deq1}, 32'd0, "after_96_deq");

    chk(deq2_n, 32'd0, "empty2_no_deq");
    chk({31'd0, tx2},   32'd1, "empty2_tx");
    chk({31'd0, busy2}, 32'd0, "empty2_busy");
    data2  = 8'hC3;
    empty2 = 1'b0;
    #1;
    chk({31'd0, deq2}, 32'd1, "sb2_deq");
    @(posedge clk);
    #1;
    empty2 = 1'b1;
    check_frame(8'hC3, 2, 2, -1, -1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk({31'd0, deq2},  32'd0, "sb2_idle_deq");
      chk({31'd0, tx2},   32'd1, "sb2_idle_tx");
      chk({31'd0, busy2}, 32'd0, "sb2_idle_busy");
    end
    chk(deq2_n, 32'd1, "sb2_deq_count");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
